clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Mode/sequencing controller for the digital-clock counter chain (seconds, minutes, hours).
- Turns two raw push-buttons (MODE, INC) into one-cycle increment/clear pulses for the counters.
- Gates normal timekeeping while a field is being set, and drives a blink enable for the display of the selected field.
- Sits between the board buttons and the counter datapath; the datapath ORs min_inc into the minute counter's carry input and hour_inc into the hour counter's carry input.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples required to accept a button level change.
- REPEAT_DELAY, 25000000: cycles INC must be held (after first accepted press) before auto-repeat starts.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat pulses while INC stays held.
- IDLE_TIMEOUT, 500000000: cycles without any accepted press in a set mode before forced return to RUN.
- BLINK_HALF, 25000000: half-period of blink in cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- mode_btn  in  1  raw MODE button, asynchronous, active-high
- inc_btn  in  1  raw INC button, asynchronous, active-high
- run_en  out  1  1 = seconds counter may count; 0 = timekeeping frozen
- hour_inc  out  1  one-cycle pulse: hours +1 (counter wraps itself)
- min_inc  out  1  one-cycle pulse: minutes +1
- sec_clr  out  1  one-cycle pulse: seconds to 0
- set_field  out  2  00 RUN, 01 HOUR, 10 MIN, 11 SEC
- blink  out  1  display blank enable for the selected field

Behaviour:
- Reset: state RUN; run_en=1; hour_inc=min_inc=sec_clr=0; set_field=00; blink=0; all counters 0; debounced levels 0.
- Conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: the debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any matching sample resets the count.
  - A press event is the debounced rising edge.
  - A registered action pulse appears exactly DEBOUNCE_CYCLES+3 cycles after a clean raw rising edge.
  - Releases generate nothing.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC.
- MODE press transitions: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
- set_field and run_en are registered and change in the cycle after the press event; run_en=1 only in RUN.
- INC press event (and each auto-repeat) by state:
  - RUN: ignored.
  - SET_HOUR: hour_inc pulse.
  - SET_MIN: min_inc pulse.
  - SET_SEC: sec_clr pulse.
- Auto-repeat:
  - Runs in SET_HOUR and SET_MIN only.
  - Hold counter starts at the INC press event; first repeat pulse at REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while the debounced INC stays 1.
  - Debounced release or any state change stops repeat immediately.
- Simultaneous MODE and INC press events in the same cycle: the MODE transition is taken and the INC press is discarded (no pulse, no repeat).
- Output pulses are exactly 1 cycle wide and mutually exclusive.
- Idle timeout:
  - The idle counter clears on every accepted press event in any set state.
  - On reaching IDLE_TIMEOUT it forces RUN, set_field=00, run_en=1.
  - Counting is inhibited while INC is held.
- Blink:
  - Forced 0 in RUN.
  - On entry to any set state the blink counter clears and blink=0; blink toggles every BLINK_HALF cycles.
  - blink is held at 0 while an INC pulse or repeat is active (field stays visible).
- Counter widths: $clog2(param+1); no counter may wrap, all saturate or clear.
- Reset mid-operation (any state, mid-debounce, mid-repeat): immediate return to reset values; a button still held after reset deasserts must be re-debounced and produces a press event.

Decomposition:
- Shared package clock_ctrl_pkg:
  - set_field encodings (FIELD_RUN, FIELD_HOUR, FIELD_MIN, FIELD_SEC).
  - FSM state typedef.
- Sub-module button_conditioner (synchronizer, debounce counter, rising-edge detect, parameter DEBOUNCE_CYCLES), instantiated twice.
- Repeat, timeout and blink logic stay in the top.

Test Plan:
- Bench params for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, IDLE_TIMEOUT=100, BLINK_HALF=8.
- Reset then idle 50 cycles -> run_en=1, set_field=00, blink=0, no pulses; INC press in RUN -> no pulse.
- MODE pulses of 3 clean cycles -> no state change (bounce rejected). Then 4 clean MODE presses, each held 10 cycles -> set_field sequence 01,10,11,00; each change 1 cycle after the debounced edge; run_en=0 during 01..11.
- In SET_MIN, hold INC for 40 cycles past debounce -> min_inc at press, +20, +25, +30, +35 (5 pulses total), each 1 cycle wide; none after release.
- In SET_SEC, press INC once -> single sec_clr pulse; hold INC 40 cycles -> still exactly one sec_clr.
- In SET_HOUR, no presses for 100 cycles -> forced to set_field=00, run_en=1; blink toggles every 8 cycles before the timeout and is 0 after it.
- MODE and INC debounced edges in the same cycle while in SET_HOUR -> moves to SET_MIN, zero hour_inc/min_inc. Assert reset mid-repeat in SET_MIN -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock-setting controller.
//   - set_field encodings driven to the display/counter datapath
//   - FSM state type for the setting sequence
//   - field_of(): maps an FSM state to its set_field encoding
package clock_ctrl_pkg;

  localparam logic [1:0] FIELD_RUN  = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  typedef enum logic [1:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC
  } state_t;

  function automatic logic [1:0] field_of(input state_t s);
    logic [1:0] f;
    case (s)
      SET_HOUR: f = FIELD_HOUR;
      SET_MIN:  f = FIELD_MIN;
      SET_SEC:  f = FIELD_SEC;
      default:  f = FIELD_RUN;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Conditions one raw push-button.
//   clk, reset : system clock, asynchronous active-high reset
//   btn        : raw asynchronous button level
//   level      : debounced button level
//   press      : one-cycle pulse on the debounced rising edge
// The debounced level only flips after DEBOUNCE_CYCLES consecutive
// synchronized samples disagree with it; any agreeing sample restarts
// the count, so short bounces never reach the outputs.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  // Combinational so the top can register its action one cycle later.
  assign press = level & ~level_q;

endmodule

// File: rtl/clock_set_controller.sv
// Mode/sequencing controller for the digital-clock counter chain.
//   clk, reset : system clock, asynchronous active-high reset
//   mode_btn   : raw MODE button (cycles RUN->HOUR->MIN->SEC->RUN)
//   inc_btn    : raw INC button (acts on the selected field, auto-repeats)
//   run_en     : 1 while timekeeping may run (RUN state only)
//   hour_inc   : one-cycle hours +1 pulse
//   min_inc    : one-cycle minutes +1 pulse
//   sec_clr    : one-cycle seconds clear pulse
//   set_field  : selected field (00 RUN, 01 HOUR, 10 MIN, 11 SEC)
//   blink      : blank enable for the selected field on the display
module clock_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int IDLE_TIMEOUT    = 500000000,
  parameter int BLINK_HALF      = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic       run_en,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic [1:0] set_field,
  output logic       blink
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam int BLINK_W  = $clog2(BLINK_HALF + 1);

  logic mode_press;
  logic mode_level_unused;
  logic inc_press;
  logic inc_level;

  state_t state_q;
  state_t state_d;

  logic              state_change;
  logic              repeat_ok;
  logic              repeat_fire;
  logic              inc_fire;
  logic              repeat_active;
  logic              in_period;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_target;
  logic [IDLE_W-1:0] idle_cnt;
  logic [BLINK_W-1:0] blink_cnt;

  // MODE release is intentionally ignored, so its debounced level is unused.
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_cond (
    .clk   (clk),
    .reset (reset),
    .btn   (mode_btn),
    .level (mode_level_unused),
    .press (mode_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_cond (
    .clk   (clk),
    .reset (reset),
    .btn   (inc_btn),
    .level (inc_level),
    .press (inc_press)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: MODE advances the field; an idle set state falls back to RUN.
  // The timeout fires on the cycle the idle count would reach IDLE_TIMEOUT.
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end else if (state_q != RUN && !inc_level &&
                 idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
      state_d = RUN;
    end
  end

  // INC actions: any state change in the same cycle (MODE press or timeout)
  // swallows the INC press or repeat so pulses never leak across fields.
  always_comb begin
    state_change = (state_d != state_q);
    repeat_ok    = (state_q == SET_HOUR) || (state_q == SET_MIN);
    hold_target  = in_period ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY);
    repeat_fire  = repeat_active && inc_level && repeat_ok && (hold_cnt == hold_target);
    inc_fire     = 1'b0;
    if (!state_change) begin
      inc_fire = (inc_press && state_q != RUN) || repeat_fire;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_field <= FIELD_RUN;
      run_en    <= 1'b1;
      hour_inc  <= 1'b0;
      min_inc   <= 1'b0;
      sec_clr   <= 1'b0;
    end else begin
      set_field <= field_of(state_d);
      run_en    <= (state_d == RUN);
      hour_inc  <= inc_fire && (state_q == SET_HOUR);
      min_inc   <= inc_fire && (state_q == SET_MIN);
      sec_clr   <= inc_fire && (state_q == SET_SEC);
    end
  end

  // Auto-repeat: hold_cnt equals cycles since the press (or last repeat),
  // so it never exceeds the larger of the two targets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      repeat_active <= 1'b0;
      in_period     <= 1'b0;
      hold_cnt      <= '0;
    end else if (state_change || !inc_level || !repeat_ok) begin
      repeat_active <= 1'b0;
      in_period     <= 1'b0;
      hold_cnt      <= '0;
    end else if (inc_press) begin
      repeat_active <= 1'b1;
      in_period     <= 1'b0;
      hold_cnt      <= HOLD_W'(1);
    end else if (repeat_active) begin
      if (repeat_fire) begin
        in_period <= 1'b1;
        hold_cnt  <= HOLD_W'(1);
      end else begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Idle counter: cleared by presses and in RUN, frozen while INC is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state_d == RUN || state_change || inc_press) begin
      idle_cnt <= '0;
    end else if (!inc_level) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // Blink restarts dark on field entry and stays dark while INC is acting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (state_d == RUN || state_change || inc_fire || repeat_active) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller with small timing parameters.
// Pulses are checked by a scoreboard: the driver pushes {kind, cycle} when
// it drives a press, and a negedge monitor pops and compares every pulse.
module tb_clock_set_controller;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int IT = 100;
  localparam int BH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       run_en;
  logic       hour_inc;
  logic       min_inc;
  logic       sec_clr;
  logic [1:0] set_field;
  logic       blink;

  clock_set_controller #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .IDLE_TIMEOUT    (IT),
    .BLINK_HALF      (BH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .run_en    (run_en),
    .hour_inc  (hour_inc),
    .min_inc   (min_inc),
    .sec_clr   (sec_clr),
    .set_field (set_field),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  typedef struct {
    logic       mode;
    logic       inc;
    logic [1:0] exp_field;
    logic       exp_run_en;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[5];

  int total = 0;
  int bad   = 0;
  int n_hour = 0;
  int n_min  = 0;
  int n_sec  = 0;

  int   mon_high;
  int   mon_kind;
  exp_t mon_e;

  // Latency from raw press (driven just after posedge k) to the action pulse.
  localparam int LAT = DB + 3;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic i);
    mode_btn = m;
    inc_btn  = i;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  task automatic pushPulse(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    expq.push_back(e);
  endtask

  task automatic doMode(input logic [1:0] exp_field);
    applyStimulus(1'b1, 1'b0);
    step(LAT);
    checkOutput("mode_field", {30'd0, set_field}, {30'd0, exp_field});
    step(3);
    applyStimulus(1'b0, 1'b0);
    step(10);
  endtask

  // Scoreboard monitor: every pulse seen must match the head of the queue.
  always @(negedge clk) begin
    if (!reset) begin
      mon_high = int'(hour_inc) + int'(min_inc) + int'(sec_clr);
      if (mon_high > 1) begin
        total++;
        bad++;
        $display("[TB] FAIL pulse_exclusive: got %0d active pulses expected 1 at cycle %0d",
                 mon_high, cyc);
      end else if (mon_high == 1) begin
        mon_kind = hour_inc ? 1 : (min_inc ? 2 : 3);
        if (mon_kind == 1) n_hour++;
        else if (mon_kind == 2) n_min++;
        else n_sec++;
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_pulse: got kind %0d at cycle %0d expected none",
                   mon_kind, cyc);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.kind != mon_kind || mon_e.at != cyc) begin
            bad++;
            $display("[TB] FAIL pulse_match: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                     mon_kind, cyc, mon_e.kind, mon_e.at);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int base;

    tbl[0] = '{mode: 1'b0, inc: 1'b1, exp_field: 2'b00, exp_run_en: 1'b1};
    tbl[1] = '{mode: 1'b1, inc: 1'b0, exp_field: 2'b01, exp_run_en: 1'b0};
    tbl[2] = '{mode: 1'b1, inc: 1'b0, exp_field: 2'b10, exp_run_en: 1'b0};
    tbl[3] = '{mode: 1'b1, inc: 1'b0, exp_field: 2'b11, exp_run_en: 1'b0};
    tbl[4] = '{mode: 1'b1, inc: 1'b0, exp_field: 2'b00, exp_run_en: 1'b1};

    // Reset values, then a quiet idle period.
    #1 reset = 1'b1;
    step(3);
    checkOutput("rst_run_en", {31'd0, run_en}, 32'd1);
    checkOutput("rst_field", {30'd0, set_field}, 32'd0);
    checkOutput("rst_blink", {31'd0, blink}, 32'd0);
    checkOutput("rst_pulses", {29'd0, hour_inc, min_inc, sec_clr}, 32'd0);
    reset = 1'b0;
    step(50);
    checkOutput("idle_run_en", {31'd0, run_en}, 32'd1);
    checkOutput("idle_field", {30'd0, set_field}, 32'd0);
    checkOutput("idle_blink", {31'd0, blink}, 32'd0);
    checkOutput("idle_pulses", n_hour + n_min + n_sec, 32'd0);

    // A 3-cycle MODE blip is a bounce and must not change state.
    applyStimulus(1'b1, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b0);
    step(15);
    checkOutput("bounce_field", {30'd0, set_field}, 32'd0);
    checkOutput("bounce_run_en", {31'd0, run_en}, 32'd1);

    // Table: INC in RUN, then the full MODE cycle with edge timing.
    for (int t = 0; t < 5; t++) begin
      logic [1:0] prev_field;
      base = n_hour + n_min + n_sec;
      prev_field = set_field;
      applyStimulus(tbl[t].mode, tbl[t].inc);
      step(LAT - 1);
      checkOutput("tbl_field_before", {30'd0, set_field}, {30'd0, prev_field});
      step(1);
      checkOutput("tbl_field_after", {30'd0, set_field}, {30'd0, tbl[t].exp_field});
      checkOutput("tbl_run_en", {31'd0, run_en}, {31'd0, tbl[t].exp_run_en});
      step(3);
      applyStimulus(1'b0, 1'b0);
      step(10);
      checkOutput("tbl_no_pulse", n_hour + n_min + n_sec - base, 32'd0);
    end

    // Auto-repeat in SET_MIN: press pulse plus four repeats, dark blink.
    doMode(2'b01);
    doMode(2'b10);
    base = n_min;
    k = cyc;
    applyStimulus(1'b0, 1'b1);
    pushPulse(2, k + LAT);
    pushPulse(2, k + LAT + RD);
    pushPulse(2, k + LAT + RD + RP);
    pushPulse(2, k + LAT + RD + 2 * RP);
    pushPulse(2, k + LAT + RD + 3 * RP);
    for (int j = 1; j <= 60; j++) begin
      step(1);
      if (j == 38) applyStimulus(1'b0, 1'b0);
      if (j >= 8 && j <= 40) checkOutput("blink_hold", {31'd0, blink}, 32'd0);
    end
    checkOutput("repeat_count", n_min - base, 32'd5);

    // SET_SEC: one clear per press, no repeat even when held.
    doMode(2'b11);
    base = n_sec;
    k = cyc;
    applyStimulus(1'b0, 1'b1);
    pushPulse(3, k + LAT);
    step(10);
    applyStimulus(1'b0, 1'b0);
    step(12);
    k = cyc;
    applyStimulus(1'b0, 1'b1);
    pushPulse(3, k + LAT);
    step(40);
    applyStimulus(1'b0, 1'b0);
    step(12);
    checkOutput("sec_clr_count", n_sec - base, 32'd2);
    doMode(2'b00);

    // SET_HOUR idle timeout with blink phase checked every cycle.
    applyStimulus(1'b1, 1'b0);
    step(LAT);
    for (int j = 0; j <= 98; j++) begin
      if (j == 3) applyStimulus(1'b0, 1'b0);
      checkOutput("blink_phase", {31'd0, blink}, (j / BH) % 2);
      if (j == 98) checkOutput("timeout_before", {30'd0, set_field}, 32'd1);
      step(1);
    end
    step(2);
    checkOutput("timeout_field", {30'd0, set_field}, 32'd0);
    checkOutput("timeout_run_en", {31'd0, run_en}, 32'd1);
    checkOutput("timeout_blink", {31'd0, blink}, 32'd0);

    // Simultaneous MODE and INC in SET_HOUR: MODE wins, INC discarded.
    doMode(2'b01);
    base = n_hour + n_min;
    applyStimulus(1'b1, 1'b1);
    step(LAT);
    checkOutput("simul_field", {30'd0, set_field}, 32'd2);
    step(3);
    applyStimulus(1'b0, 1'b0);
    step(12);
    checkOutput("simul_no_pulse", n_hour + n_min - base, 32'd0);

    // Reset in the middle of an auto-repeat in SET_MIN.
    k = cyc;
    applyStimulus(1'b0, 1'b1);
    pushPulse(2, k + LAT);
    pushPulse(2, k + LAT + RD);
    step(30);
    checkOutput("pre_reset_field", {30'd0, set_field}, 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("midrst_run_en", {31'd0, run_en}, 32'd1);
    checkOutput("midrst_field", {30'd0, set_field}, 32'd0);
    checkOutput("midrst_pulses", {29'd0, hour_inc, min_inc, sec_clr}, 32'd0);
    checkOutput("midrst_blink", {31'd0, blink}, 32'd0);
    step(3);
    reset = 1'b0;
    step(15);
    checkOutput("post_rst_field", {30'd0, set_field}, 32'd0);
    checkOutput("post_rst_run_en", {31'd0, run_en}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    step(12);

    checkOutput("missing_pulses", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
